ddr_cmd_queue: RTL

Transaction request queue that sits directly upstream of the DDR controller command interface. It buffers read/write requests from the stimulus generator in a FIFO and presents the head entry to the controller with an `act_cmd`/`next_cmd` handshake. It holds off issue while the device is busy. It sequences burst-length (MR0) updates so that an MRS is issued only once the controller has no read/write in flight.

---
 rtl/ddr_cmd_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ddr_cmd_queue.sv
// Request FIFO in front of the DDR controller command port. Issues the head entry
// with an act_cmd/next_cmd handshake and sequences MR0 burst-length updates.
module ddr_cmd_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_rw,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     req_err,
    output logic                     act_cmd,
    output logic [1:0]               dev_rw,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [DATA_W-1:0]        cmd_data,
    input  logic                     next_cmd,
    input  logic                     dev_busy,
    input  logic                     rw_proc,
    input  logic                     bl_req_valid,
    input  logic [1:0]               bl_req,
    output logic                     mrs_update,
    output logic [1:0]               bl_update,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, MRS} state_t;

    state_t            state;
    logic [1:0]        bl_pend;
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic [1:0]        mem_rw   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic full, empty, legal, push, pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign legal     = (req_rw == 2'b01) || (req_rw == 2'b10);
    assign push      = req_valid && req_ready && legal;
    assign act_cmd   = !empty && !dev_busy && (state == RUN);
    assign pop       = act_cmd && next_cmd;
    assign q_count   = count;

    // Head is read straight from storage; zeroed when empty so idle outputs are clean.
    assign dev_rw   = empty ? 2'b00 : mem_rw[rptr];
    assign cmd_addr = empty ? '0 : mem_addr[rptr];
    assign cmd_data = empty ? '0 : mem_data[rptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_rw[wptr]   <= req_rw;
            mem_addr[wptr] <= req_addr;
            mem_data[wptr] <= req_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            req_err <= 1'b0;
        end else begin
            req_err <= req_valid && req_ready && !legal;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            bl_pend    <= 2'b00;
            bl_update  <= 2'b00;
            mrs_update <= 1'b0;
        end else begin
            mrs_update <= 1'b0;
            case (state)
                RUN: begin
                    if (bl_req_valid) begin
                        bl_pend <= bl_req;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bl_req_valid) bl_pend <= bl_req;
                    if (!rw_proc && !dev_busy) begin
                        // A request landing on the exit cycle is the one that gets written.
                        state      <= MRS;
                        mrs_update <= 1'b1;
                        bl_update  <= bl_req_valid ? bl_req : bl_pend;
                    end
                end
                MRS: begin
                    if (bl_req_valid) begin
                        bl_pend <= bl_req;
                        state   <= DRAIN;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
